redmule_job_ctx_queue: RTL and testbench

REDMULE_JOB_CTX_QUEUE -- requirements
Module: redmule_job_ctx_queue

---
 rtl/redmule_job_ctx_queue.sv | 179 +++++++++++++++++
 tb/tb_redmule_job_ctx_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_job_ctx_queue.sv
// Ring of NumCtx job-register contexts between a register slave port and a job offload handshake.
// Build option: define REDMULE_CTX_COPY_EN to carry committed registers into the next context.
module redmule_job_ctx_queue #(
    parameter int unsigned NumCtx  = 2,
    parameter int unsigned NumRegs = 22,
    parameter int unsigned IdW     = 8,
    localparam int unsigned AddrW  = $clog2(NumRegs),
    localparam int unsigned CtxW   = $clog2(NumCtx),
    localparam int unsigned CntW   = $clog2(NumCtx) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    reg_req_i,
    input  logic                    reg_we_i,
    input  logic [3:0]              reg_be_i,
    input  logic [AddrW-1:0]        reg_addr_i,
    input  logic [31:0]             reg_wdata_i,
    output logic                    reg_gnt_o,
    output logic                    reg_rvalid_o,
    output logic [31:0]             reg_rdata_o,
    input  logic                    trigger_i,
    output logic                    job_valid_o,
    input  logic                    job_ready_i,
    output logic [NumRegs*32-1:0]   job_regs_o,
    output logic [IdW-1:0]          job_id_o,
    input  logic                    done_i,
    output logic [CntW-1:0]         free_cnt_o,
    output logic                    busy_o,
    output logic                    evt_o,
    output logic                    err_o
);

    localparam logic [1:0] FREE    = 2'd0;
    localparam logic [1:0] QUEUED  = 2'd1;
    localparam logic [1:0] RUNNING = 2'd2;

    logic [1:0]      ctx_state [NumCtx];
    logic [1:0]      state_n   [NumCtx];
    logic [31:0]     ctx_regs  [NumCtx][NumRegs];
    logic [IdW-1:0]  ctx_id    [NumCtx];
    logic [CtxW-1:0] wr_ptr, run_ptr, done_ptr;
    logic [CtxW-1:0] wr_ptr_n, run_ptr_n, done_ptr_n;
    logic [IdW-1:0]  id_cnt;
    logic [CntW-1:0] free_n;
    logic            wr_free, commit, drop, dispatch, retire, addr_ok;
    logic            job_valid_q, rvalid_q, busy_q, evt_q, err_q;
    logic [31:0]     rdata_q;
    logic [CntW-1:0] free_cnt_q;

    // Contexts are filled, dispatched and retired strictly in ring order, so the
    // context at wr_ptr being non-FREE means every context is occupied.
    assign wr_free   = ctx_state[wr_ptr] == FREE;
    assign commit    = trigger_i && wr_free;
    assign drop      = trigger_i && !wr_free;
    assign dispatch  = job_valid_q && job_ready_i;
    assign retire    = done_i && (ctx_state[done_ptr] == RUNNING);
    assign addr_ok   = 32'(reg_addr_i) < NumRegs;
    assign reg_gnt_o = reg_req_i && wr_free;

    assign wr_ptr_n   = wr_ptr + CtxW'(commit);
    assign run_ptr_n  = run_ptr + CtxW'(dispatch);
    assign done_ptr_n = done_ptr + CtxW'(retire);

    // The three events always target distinct contexts (FREE / QUEUED / RUNNING).
    always_comb begin
        state_n = ctx_state;
        if (retire)   state_n[done_ptr] = FREE;
        if (dispatch) state_n[run_ptr]  = RUNNING;
        if (commit)   state_n[wr_ptr]   = QUEUED;
    end

    always_comb begin
        free_n = '0;
        for (int c = 0; c < NumCtx; c++) begin
            if (state_n[c] == FREE) free_n = free_n + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumCtx; c++) ctx_state[c] <= FREE;
            wr_ptr      <= '0;
            run_ptr     <= '0;
            done_ptr    <= '0;
            id_cnt      <= '0;
            job_valid_q <= 1'b0;
            free_cnt_q  <= CntW'(NumCtx);
            busy_q      <= 1'b0;
            evt_q       <= 1'b0;
            err_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ctx_state   <= state_n;
            wr_ptr      <= wr_ptr_n;
            run_ptr     <= run_ptr_n;
            done_ptr    <= done_ptr_n;
            job_valid_q <= state_n[run_ptr_n] == QUEUED;
            free_cnt_q  <= free_n;
            busy_q      <= free_n != CntW'(NumCtx);
            evt_q       <= retire;
            err_q       <= drop;
            rvalid_q    <= reg_gnt_o && !reg_we_i;
            rdata_q     <= (reg_gnt_o && !reg_we_i && addr_ok) ? ctx_regs[wr_ptr][reg_addr_i] : '0;
            if (commit) id_cnt <= id_cnt + IdW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit && !rst_i) ctx_id[wr_ptr] <= id_cnt;
    end

`ifdef REDMULE_CTX_COPY_EN
    logic [CtxW-1:0] copy_dst, copy_src_q, copy_dst_q;
    logic            copy_pend_q, copy_now, copy_late;

    // If the successor is still occupied, the copy is deferred to the edge that frees it.
    assign copy_dst  = wr_ptr + CtxW'(1);
    assign copy_now  = commit && ((ctx_state[copy_dst] == FREE) || (retire && (done_ptr == copy_dst)));
    assign copy_late = copy_pend_q && retire && (done_ptr == copy_dst_q);

    always_ff @(posedge clk_i) begin
        if (rst_i)                    copy_pend_q <= 1'b0;
        else if (commit && !copy_now) copy_pend_q <= 1'b1;
        else if (copy_late)           copy_pend_q <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (commit) begin
            copy_src_q <= wr_ptr;
            copy_dst_q <= copy_dst;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumCtx; c++) begin
                for (int r = 0; r < NumRegs; r++) ctx_regs[c][r] <= '0;
            end
        end else begin
`ifdef REDMULE_CTX_COPY_EN
            if (copy_now) begin
                for (int r = 0; r < NumRegs; r++) ctx_regs[copy_dst][r] <= ctx_regs[wr_ptr][r];
            end
            if (copy_late) begin
                for (int r = 0; r < NumRegs; r++) ctx_regs[copy_dst_q][r] <= ctx_regs[copy_src_q][r];
            end
`else
            if (retire) begin
                for (int r = 0; r < NumRegs; r++) ctx_regs[done_ptr][r] <= '0;
            end
`endif
            if (reg_gnt_o && reg_we_i && addr_ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_be_i[b]) ctx_regs[wr_ptr][reg_addr_i][8*b +: 8] <= reg_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // A QUEUED context is never written, so the offered job stays stable until taken.
    always_comb begin
        job_regs_o = '0;
        for (int r = 0; r < NumRegs; r++) begin
            if (job_valid_q) job_regs_o[32*r +: 32] = ctx_regs[run_ptr][r];
        end
    end

    assign job_id_o     = job_valid_q ? ctx_id[run_ptr] : '0;
    assign job_valid_o  = job_valid_q;
    assign reg_rvalid_o = rvalid_q;
    assign reg_rdata_o  = rdata_q;
    assign free_cnt_o   = free_cnt_q;
    assign busy_o       = busy_q;
    assign evt_o        = evt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_redmule_job_ctx_queue.sv
// Bench for redmule_job_ctx_queue: directed scenarios plus random traffic against a queue-based model.
module tb_redmule_job_ctx_queue;

    localparam int N = 2;
    localparam int R = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, req, we, trig, ready, done;
    logic [3:0]   be;
    logic [4:0]   addr;
    logic [31:0]  wdata;

    logic         gnt, rvalid, valid, busy, evt, err;
    logic [31:0]  rdata;
    logic [R*32-1:0] regs;
    logic [7:0]   jid;
    logic [1:0]   free_cnt;

    logic         gnt4, rvalid4, valid4, busy4, evt4, err4;
    logic [31:0]  rdata4;
    logic [R*32-1:0] regs4;
    logic [7:0]   jid4;
    logic [2:0]   free_cnt4;

    redmule_job_ctx_queue #(.NumCtx(N), .NumRegs(R), .IdW(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_req_i(req), .reg_we_i(we), .reg_be_i(be), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_gnt_o(gnt), .reg_rvalid_o(rvalid), .reg_rdata_o(rdata),
        .trigger_i(trig), .job_valid_o(valid), .job_ready_i(ready), .job_regs_o(regs), .job_id_o(jid),
        .done_i(done), .free_cnt_o(free_cnt), .busy_o(busy), .evt_o(evt), .err_o(err)
    );

    redmule_job_ctx_queue #(.NumCtx(4), .NumRegs(R), .IdW(8)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .reg_req_i(req), .reg_we_i(we), .reg_be_i(be), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_gnt_o(gnt4), .reg_rvalid_o(rvalid4), .reg_rdata_o(rdata4),
        .trigger_i(trig), .job_valid_o(valid4), .job_ready_i(ready), .job_regs_o(regs4), .job_id_o(jid4),
        .done_i(done), .free_cnt_o(free_cnt4), .busy_o(busy4), .evt_o(evt4), .err_o(err4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: jobs waiting and jobs running as FIFOs, context index = commit count mod N.
    typedef struct { int ctx; int id; } job_t;
    job_t        mq[$];
    job_t        mr[$];
    logic [31:0] mregs [N][R];
    int          commits;
    int          idcnt;

    function automatic void model_reset();
        mq.delete();
        mr.delete();
        for (int c = 0; c < N; c++) for (int r = 0; r < R; r++) mregs[c][r] = '0;
        commits = 0;
        idcnt   = 0;
    endfunction

    task automatic idle();
        rst = 0; req = 0; we = 0; be = 4'h0; addr = '0; wdata = '0;
        trig = 0; ready = 0; done = 0;
    endtask

    task automatic cycle();
        int          nfree, wctx, k;
        bit          exp_gnt, exp_rd, exp_dn, exp_err, aok;
        logic [31:0] exp_rdata;
        job_t        j;
        #1;
        nfree   = N - mq.size() - mr.size();
        wctx    = commits % N;
        exp_gnt = req && (nfree > 0);
        check_val("gnt", gnt, exp_gnt);
        aok = int'(addr) < R;
        exp_rd = 0; exp_dn = 0; exp_err = 0; exp_rdata = '0;
        if (rst) begin
            model_reset();
        end else begin
            exp_rd = exp_gnt && !we;
            if (exp_rd && aok) exp_rdata = mregs[wctx][addr];
            if (exp_gnt && we && aok) begin
                for (int b = 0; b < 4; b++) if (be[b]) mregs[wctx][addr][8*b +: 8] = wdata[8*b +: 8];
            end
            exp_dn  = done && (mr.size() > 0);
            exp_err = trig && (nfree == 0);
            if (exp_dn) begin
                j = mr.pop_front();
                for (int r = 0; r < R; r++) mregs[j.ctx][r] = '0;
            end
            if ((mq.size() > 0) && ready) begin
                j = mq.pop_front();
                mr.push_back(j);
            end
            if (trig && (nfree > 0)) begin
                mq.push_back('{ctx: wctx, id: idcnt});
                idcnt = (idcnt + 1) % 256;
                commits++;
            end
        end
        @(posedge clk);
        #1;
        check_val("free_cnt", free_cnt, N - mq.size() - mr.size());
        check_val("busy", busy, (mq.size() + mr.size()) > 0);
        check_val("valid", valid, mq.size() > 0);
        check_val("evt", evt, exp_dn);
        check_val("err", err, exp_err);
        check_val("rvalid", rvalid, exp_rd);
        if (exp_rd) check_val("rdata", rdata, exp_rdata);
        if (mq.size() > 0) begin
            k = $urandom_range(R - 1, 0);
            check_val("job_id", jid, mq[0].id);
            check_val($sformatf("job_reg%0d", k), regs[32*k +: 32], mregs[mq[0].ctx][k]);
        end
    endtask

    task automatic do_reset();
        idle(); rst = 1; cycle(); rst = 0;
    endtask

    task automatic reg_write(input int a, input logic [31:0] d, input logic [3:0] b);
        req = 1; we = 1; addr = 5'(a); wdata = d; be = b; cycle(); req = 0; we = 0;
    endtask

    task automatic reg_read(input int a);
        req = 1; we = 0; addr = 5'(a); cycle(); req = 0;
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1; cycle(); cycle(); rst = 0;
        check_val("rst_free", free_cnt, 2);
        check_val("rst_busy", busy, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_jid", jid, 0);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_free4", free_cnt4, 4);

        // Commit, dispatch and retire on the same edge (4-context instance).
        trig = 1; cycle();
        ready = 1; cycle();
        check_val("tri_pre_free4", free_cnt4, 2);
        check_val("tri_pre_jid4", jid4, 1);
        done = 1; cycle();
        check_val("tri_free4", free_cnt4, 2);
        check_val("tri_evt4", evt4, 1);
        check_val("tri_jid4", jid4, 2);
        check_val("tri_valid4", valid4, 1);
        idle();
        do_reset();

        // Byte-enable partial write and readback, plus out-of-range accesses.
        reg_write(3, 32'hAABBCCDD, 4'b0011);
        reg_read(3);
        check_val("be_rvalid", rvalid, 1);
        check_val("be_rdata", rdata, 32'h0000CCDD);
        reg_write(30, 32'h12345678, 4'hF);
        reg_read(30);
        check_val("oor_rdata", rdata, 0);

        // First job: valid one cycle after trigger with its registers and id 0.
        do_reset();
        reg_write(0, 32'h1000, 4'hF);
        reg_write(5, 32'h0000_0401, 4'hF);
        trig = 1; ready = 1; cycle(); trig = 0;
        check_val("job0_valid", valid, 1);
        check_val("job0_reg0", regs[31:0], 32'h1000);
        check_val("job0_reg5", regs[5*32 +: 32], 32'h401);
        check_val("job0_id", jid, 0);
        cycle(); ready = 0;
        check_val("job0_taken_valid", valid, 0);
        check_val("job0_taken_free", free_cnt, 1);

        // Over-commit: third trigger drops, access stalls until a job retires.
        do_reset();
        trig = 1; cycle(); cycle();
        check_val("full_err2", err, 0);
        cycle(); trig = 0;
        check_val("full_err3", err, 1);
        check_val("full_free", free_cnt, 0);
        cycle();
        check_val("err_pulse", err, 0);
        req = 1; we = 1; addr = 5'd7; wdata = 32'hDEADBEEF; be = 4'hF;
        #1; check_val("stall_gnt", gnt, 0);
        ready = 1; cycle(); ready = 0;
        check_val("stall_gnt_run", gnt, 0);
        done = 1; cycle(); done = 0;
        check_val("stall_evt", evt, 1);
        check_val("stall_free", free_cnt, 1);
        #1; check_val("gnt_after_done", gnt, 1);
        cycle(); idle();

        // Freed contexts come back cleared: no carry-over of earlier fields.
        do_reset();
        reg_write(1, 32'h55, 4'hF);
        trig = 1; cycle(); trig = 0;
        reg_write(2, 32'h77, 4'hF);
        trig = 1; cycle(); trig = 0;
        ready = 1; cycle();
        check_val("job1_reg2", regs[2*32 +: 32], 32'h77);
        check_val("job1_reg1", regs[1*32 +: 32], 0);
        cycle(); ready = 0;
        done = 1; cycle(); cycle(); done = 0;
        trig = 1; cycle(); trig = 0;
        reg_read(1);
        check_val("reuse_reg1", rdata, 0);
        reg_read(2);
        check_val("reuse_reg2", rdata, 0);

        // Reset with two jobs running.
        do_reset();
        trig = 1; cycle();
        ready = 1; cycle(); trig = 0;
        cycle(); ready = 0;
        check_val("run2_free", free_cnt, 0);
        rst = 1; cycle(); rst = 0;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_free", free_cnt, 2);
        done = 1; cycle(); done = 0;
        check_val("midrst_evt", evt, 0);
        check_val("midrst_free2", free_cnt, 2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(99, 0) < 2);
            req   = $urandom_range(1, 0);
            we    = $urandom_range(1, 0);
            be    = 4'($urandom);
            addr  = 5'($urandom_range(31, 0));
            wdata = $urandom;
            trig  = ($urandom_range(3, 0) == 0);
            ready = $urandom_range(1, 0);
            done  = ($urandom_range(3, 0) == 0);
            cycle();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
